// File: rtl/shift_scheduler_if.sv
// rtl/shift_scheduler_if.sv - requester, response and shifter-side signals of shift_scheduler
interface shift_scheduler_if;
  logic       Req_Valid_A;
  logic       Req_Valid_B;
  logic       Req_Ready_A;
  logic       Req_Ready_B;
  logic [1:0] Req_Op_A;
  logic [1:0] Req_Op_B;
  logic [2:0] Req_Amount_A;
  logic [2:0] Req_Amount_B;
  logic [7:0] Req_Data_A;
  logic [7:0] Req_Data_B;
  logic       Rsp_Valid;
  logic       Rsp_Ready;
  logic       Rsp_Id;
  logic [7:0] Rsp_Data;
  logic       Busy;
  logic       Sh_Direction;
  logic [2:0] Sh_Shift_Amount;
  logic [7:0] Sh_Data_In;
  logic [7:0] Sh_Data_Out;

  // Scheduler side.
  modport slave (
    input  Req_Valid_A, Req_Valid_B, Req_Op_A, Req_Op_B,
    input  Req_Amount_A, Req_Amount_B, Req_Data_A, Req_Data_B,
    input  Rsp_Ready, Sh_Data_Out,
    output Req_Ready_A, Req_Ready_B, Rsp_Valid, Rsp_Id, Rsp_Data, Busy,
    output Sh_Direction, Sh_Shift_Amount, Sh_Data_In
  );

  // Requesters, response consumer and shifter side.
  modport master (
    output Req_Valid_A, Req_Valid_B, Req_Op_A, Req_Op_B,
    output Req_Amount_A, Req_Amount_B, Req_Data_A, Req_Data_B,
    output Rsp_Ready, Sh_Data_Out,
    input  Req_Ready_A, Req_Ready_B, Rsp_Valid, Rsp_Id, Rsp_Data, Busy,
    input  Sh_Direction, Sh_Shift_Amount, Sh_Data_In
  );
endinterface

// File: rtl/shift_scheduler.sv
// rtl/shift_scheduler.sv - round-robin two-port scheduler driving an 8-bit shifter
// Rotates are built from a shift one way plus a shift the other way, ORed together.
module shift_scheduler (
  input logic              Clock,
  input logic              Reset_n,
  shift_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PASS1 = 3'd1,
    CAP1  = 3'd2,
    PASS2 = 3'd3,
    CAP2  = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [1:0] op_q, op_d;
  logic [2:0] amt_q, amt_d;
  logic [7:0] data_q, data_d;
  logic       id_q, id_d;
  logic [7:0] partial_q, partial_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_id_q, rsp_id_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       busy_q, busy_d;
  logic       sh_dir_q, sh_dir_d;
  logic [2:0] sh_amt_q, sh_amt_d;
  logic [7:0] sh_din_q, sh_din_d;

  logic       grant_a, grant_b;
  logic       ready_a, ready_b;
  logic [1:0] sel_op;
  logic [2:0] sel_amt;
  logic [7:0] sel_data;

  // On a tie, the port not served last wins; last_grant_q = 1 means B was last.
  always_comb begin
    grant_a  = bus.Req_Valid_A && (!bus.Req_Valid_B || last_grant_q);
    grant_b  = bus.Req_Valid_B && !grant_a;
    ready_a  = Reset_n && (state_q == IDLE) && grant_a;
    ready_b  = Reset_n && (state_q == IDLE) && grant_b;
    sel_op   = ready_b ? bus.Req_Op_B     : bus.Req_Op_A;
    sel_amt  = ready_b ? bus.Req_Amount_B : bus.Req_Amount_A;
    sel_data = ready_b ? bus.Req_Data_B   : bus.Req_Data_A;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    amt_d        = amt_q;
    data_d       = data_q;
    id_d         = id_q;
    partial_d    = partial_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    sh_dir_d     = 1'b0;
    sh_amt_d     = 3'd0;
    sh_din_d     = 8'd0;

    // Shifter inputs are registered, so they are loaded on the edge entering each PASS state.
    case (state_q)
      IDLE: begin
        if (ready_a || ready_b) begin
          op_d         = sel_op;
          amt_d        = sel_amt;
          data_d       = sel_data;
          id_d         = ready_b;
          last_grant_d = ready_b;
          state_d      = PASS1;
          sh_dir_d     = sel_op[0];
          sh_amt_d     = sel_amt;
          sh_din_d     = sel_data;
        end
      end
      PASS1: state_d = CAP1;
      CAP1: begin
        partial_d = bus.Sh_Data_Out;
        if (!op_q[1] || (amt_q == 3'd0)) begin
          rsp_data_d = bus.Sh_Data_Out;
          rsp_id_d   = id_q;
          state_d    = RESP;
        end else begin
          state_d  = PASS2;
          sh_dir_d = ~op_q[0];
          sh_amt_d = ~amt_q + 3'd1;
          sh_din_d = data_q;
        end
      end
      PASS2: state_d = CAP2;
      CAP2: begin
        rsp_data_d = partial_q | bus.Sh_Data_Out;
        rsp_id_d   = id_q;
        state_d    = RESP;
      end
      RESP: begin
        if (bus.Rsp_Ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= 2'd0;
      amt_q        <= 3'd0;
      data_q       <= 8'd0;
      id_q         <= 1'b0;
      partial_q    <= 8'd0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= 8'd0;
      busy_q       <= 1'b0;
      sh_dir_q     <= 1'b0;
      sh_amt_q     <= 3'd0;
      sh_din_q     <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      amt_q        <= amt_d;
      data_q       <= data_d;
      id_q         <= id_d;
      partial_q    <= partial_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      busy_q       <= busy_d;
      sh_dir_q     <= sh_dir_d;
      sh_amt_q     <= sh_amt_d;
      sh_din_q     <= sh_din_d;
    end
  end

  assign bus.Req_Ready_A     = ready_a;
  assign bus.Req_Ready_B     = ready_b;
  assign bus.Rsp_Valid       = rsp_valid_q;
  assign bus.Rsp_Id          = rsp_id_q;
  assign bus.Rsp_Data        = rsp_data_q;
  assign bus.Busy            = busy_q;
  assign bus.Sh_Direction    = sh_dir_q;
  assign bus.Sh_Shift_Amount = sh_amt_q;
  assign bus.Sh_Data_In      = sh_din_q;

endmodule

// File: tb/tb_shift_scheduler.sv
// tb/tb_shift_scheduler.sv - directed self-checking bench for shift_scheduler
module tb_shift_scheduler;

  logic Clock = 1'b0;
  logic Reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  shift_scheduler_if bus();

  shift_scheduler dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clock = ~Clock;

  // Shifter model: registered, one-cycle latency.
  logic [7:0] sh_q;
  always_ff @(posedge Clock) begin
    sh_q <= bus.Sh_Direction ? (bus.Sh_Data_In >> bus.Sh_Shift_Amount)
                             : (bus.Sh_Data_In << bus.Sh_Shift_Amount);
  end
  assign bus.Sh_Data_Out = sh_q;

  task automatic clear_reqs();
    bus.Req_Valid_A  = 1'b0;
    bus.Req_Valid_B  = 1'b0;
    bus.Req_Op_A     = 2'd0;
    bus.Req_Op_B     = 2'd0;
    bus.Req_Amount_A = 3'd0;
    bus.Req_Amount_B = 3'd0;
    bus.Req_Data_A   = 8'd0;
    bus.Req_Data_B   = 8'd0;
  endtask

  task automatic drive_a(input logic [1:0] op, input logic [2:0] amt, input logic [7:0] d);
    bus.Req_Valid_A  = 1'b1;
    bus.Req_Op_A     = op;
    bus.Req_Amount_A = amt;
    bus.Req_Data_A   = d;
  endtask

  task automatic drive_b(input logic [1:0] op, input logic [2:0] amt, input logic [7:0] d);
    bus.Req_Valid_B  = 1'b1;
    bus.Req_Op_B     = op;
    bus.Req_Amount_B = amt;
    bus.Req_Data_B   = d;
  endtask

  task automatic test_reset();
    clear_reqs();
    bus.Rsp_Ready = 1'b1;
    Reset_n = 1'b0;
    drive_a(2'b00, 3'd1, 8'hFF);
    @(negedge Clock);
    checks++; if (bus.Req_Ready_A !== 1'b0) begin failures++; $display("FAIL reset_ready_a got=%b exp=0", bus.Req_Ready_A); end
    checks++; if (bus.Rsp_Valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.Rsp_Valid); end
    checks++; if (bus.Rsp_Id !== 1'b0 || bus.Rsp_Data !== 8'h00) begin failures++; $display("FAIL reset_rsp id=%b data=%h exp 0/00", bus.Rsp_Id, bus.Rsp_Data); end
    checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.Busy); end
    checks++; if ({bus.Sh_Direction, bus.Sh_Shift_Amount, bus.Sh_Data_In} !== 12'h000) begin failures++; $display("FAIL reset_sh dir=%b amt=%0d din=%h exp all 0", bus.Sh_Direction, bus.Sh_Shift_Amount, bus.Sh_Data_In); end
    clear_reqs();
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_shl();
    int lat;
    drive_a(2'b00, 3'd3, 8'h81);
    #1;
    checks++; if (bus.Req_Ready_A !== 1'b1 || bus.Req_Ready_B !== 1'b0) begin failures++; $display("FAIL shl_ready a=%b b=%b exp 1/0", bus.Req_Ready_A, bus.Req_Ready_B); end
    @(negedge Clock);
    clear_reqs();
    checks++; if (bus.Sh_Direction !== 1'b0 || bus.Sh_Shift_Amount !== 3'd3 || bus.Sh_Data_In !== 8'h81) begin failures++; $display("FAIL shl_pass1 dir=%b amt=%0d din=%h exp 0/3/81", bus.Sh_Direction, bus.Sh_Shift_Amount, bus.Sh_Data_In); end
    lat = 1;
    while (bus.Rsp_Valid !== 1'b1 && lat < 12) begin @(negedge Clock); lat++; end
    checks++; if (lat !== 3) begin failures++; $display("FAIL shl_latency got=%0d exp=3", lat); end
    checks++; if (bus.Rsp_Data !== 8'h08 || bus.Rsp_Id !== 1'b0) begin failures++; $display("FAIL shl_result data=%h id=%b exp 08/0", bus.Rsp_Data, bus.Rsp_Id); end
    @(negedge Clock);
    checks++; if (bus.Busy !== 1'b0 || bus.Rsp_Valid !== 1'b0) begin failures++; $display("FAIL shl_idle busy=%b valid=%b exp 0/0", bus.Busy, bus.Rsp_Valid); end
  endtask

  task automatic test_ror();
    int lat;
    drive_b(2'b11, 3'd3, 8'h81);
    #1;
    checks++; if (bus.Req_Ready_B !== 1'b1) begin failures++; $display("FAIL ror_ready_b got=%b exp=1", bus.Req_Ready_B); end
    @(negedge Clock);
    clear_reqs();
    checks++; if (bus.Sh_Direction !== 1'b1 || bus.Sh_Shift_Amount !== 3'd3) begin failures++; $display("FAIL ror_pass1 dir=%b amt=%0d exp 1/3", bus.Sh_Direction, bus.Sh_Shift_Amount); end
    @(negedge Clock);
    @(negedge Clock);
    checks++; if (bus.Sh_Direction !== 1'b0 || bus.Sh_Shift_Amount !== 3'd5 || bus.Sh_Data_In !== 8'h81) begin failures++; $display("FAIL ror_pass2 dir=%b amt=%0d din=%h exp 0/5/81", bus.Sh_Direction, bus.Sh_Shift_Amount, bus.Sh_Data_In); end
    lat = 3;
    while (bus.Rsp_Valid !== 1'b1 && lat < 12) begin @(negedge Clock); lat++; end
    checks++; if (lat !== 5) begin failures++; $display("FAIL ror_latency got=%0d exp=5", lat); end
    checks++; if (bus.Rsp_Data !== 8'h30 || bus.Rsp_Id !== 1'b1) begin failures++; $display("FAIL ror_result data=%h id=%b exp 30/1", bus.Rsp_Data, bus.Rsp_Id); end
    @(negedge Clock);
  endtask

  task automatic test_rol();
    int lat;
    drive_a(2'b10, 3'd1, 8'h80);
    @(negedge Clock);
    clear_reqs();
    lat = 1;
    while (bus.Rsp_Valid !== 1'b1 && lat < 12) begin @(negedge Clock); lat++; end
    checks++; if (lat !== 5) begin failures++; $display("FAIL rol_latency got=%0d exp=5", lat); end
    checks++; if (bus.Rsp_Data !== 8'h01 || bus.Rsp_Id !== 1'b0) begin failures++; $display("FAIL rol_result data=%h id=%b exp 01/0", bus.Rsp_Data, bus.Rsp_Id); end
    @(negedge Clock);
  endtask

  task automatic test_rot0();
    drive_a(2'b10, 3'd0, 8'h5A);
    @(negedge Clock);
    clear_reqs();
    @(negedge Clock);
    @(negedge Clock);
    checks++; if (bus.Rsp_Valid !== 1'b1 || bus.Rsp_Data !== 8'h5A) begin failures++; $display("FAIL rot0_c3 valid=%b data=%h exp 1/5a", bus.Rsp_Valid, bus.Rsp_Data); end
    checks++; if (bus.Sh_Shift_Amount !== 3'd0 || bus.Sh_Data_In !== 8'h00) begin failures++; $display("FAIL rot0_no_pass2 amt=%0d din=%h exp 0/00", bus.Sh_Shift_Amount, bus.Sh_Data_In); end
    @(negedge Clock);
    checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL rot0_idle busy=%b exp=0", bus.Busy); end
  endtask

  task automatic test_back_to_back();
    logic       g [8];
    logic       ids [4];
    logic [7:0] dat [4];
    int         ng, nr;
    logic       both;
    Reset_n = 1'b0;
    bus.Rsp_Ready = 1'b1;
    drive_a(2'b00, 3'd1, 8'h01);
    drive_b(2'b00, 3'd1, 8'h02);
    @(negedge Clock);
    Reset_n = 1'b1;
    ng = 0; nr = 0; both = 1'b0;
    for (int cyc = 0; cyc < 60 && nr < 4; cyc++) begin
      #1;
      if (bus.Req_Ready_A && bus.Req_Ready_B) both = 1'b1;
      if (bus.Req_Ready_A && ng < 8) begin g[ng] = 1'b0; ng++; end
      if (bus.Req_Ready_B && ng < 8) begin g[ng] = 1'b1; ng++; end
      if (bus.Rsp_Valid === 1'b1) begin ids[nr] = bus.Rsp_Id; dat[nr] = bus.Rsp_Data; nr++; end
      @(negedge Clock);
    end
    clear_reqs();
    checks++; if (nr !== 4 || ng < 4) begin failures++; $display("FAIL b2b_count responses=%0d grants=%0d exp 4/>=4", nr, ng); end
    checks++; if (both !== 1'b0) begin failures++; $display("FAIL b2b_dual_ready got=%b exp=0", both); end
    if (nr == 4 && ng >= 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (g[i] !== i[0]) begin failures++; $display("FAIL b2b_grant[%0d] got=%b exp=%b", i, g[i], i[0]); end
        checks++; if (ids[i] !== i[0] || dat[i] !== (i[0] ? 8'h04 : 8'h02)) begin failures++; $display("FAIL b2b_rsp[%0d] id=%b data=%h exp %b/%h", i, ids[i], dat[i], i[0], (i[0] ? 8'h04 : 8'h02)); end
      end
    end
    for (int k = 0; k < 20 && (bus.Busy === 1'b1 || bus.Rsp_Valid === 1'b1); k++) @(negedge Clock);
  endtask

  task automatic test_backpressure();
    int lat;
    bus.Rsp_Ready = 1'b0;
    drive_b(2'b01, 3'd2, 8'hF0);
    @(negedge Clock);
    clear_reqs();
    lat = 1;
    while (bus.Rsp_Valid !== 1'b1 && lat < 12) begin @(negedge Clock); lat++; end
    checks++; if (lat !== 3) begin failures++; $display("FAIL bp_latency got=%0d exp=3", lat); end
    drive_a(2'b00, 3'd0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.Rsp_Valid !== 1'b1 || bus.Rsp_Data !== 8'h3C || bus.Rsp_Id !== 1'b1) begin failures++; $display("FAIL bp_hold[%0d] valid=%b data=%h id=%b exp 1/3c/1", i, bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Id); end
      checks++; if (bus.Req_Ready_A !== 1'b0 || bus.Req_Ready_B !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d] a=%b b=%b exp 0/0", i, bus.Req_Ready_A, bus.Req_Ready_B); end
      @(negedge Clock);
    end
    clear_reqs();
    bus.Rsp_Ready = 1'b1;
    #1;
    checks++; if (bus.Rsp_Valid !== 1'b1) begin failures++; $display("FAIL bp_release_valid got=%b exp=1", bus.Rsp_Valid); end
    @(negedge Clock);
    checks++; if (bus.Busy !== 1'b0 || bus.Rsp_Valid !== 1'b0) begin failures++; $display("FAIL bp_idle busy=%b valid=%b exp 0/0", bus.Busy, bus.Rsp_Valid); end
  endtask

  task automatic test_reset_in_pass2();
    int lat;
    bus.Rsp_Ready = 1'b1;
    drive_b(2'b11, 3'd3, 8'h81);
    @(negedge Clock);
    clear_reqs();
    @(negedge Clock);
    @(negedge Clock);
    checks++; if (bus.Sh_Shift_Amount !== 3'd5 || bus.Busy !== 1'b1) begin failures++; $display("FAIL rst2_in_pass2 amt=%0d busy=%b exp 5/1", bus.Sh_Shift_Amount, bus.Busy); end
    Reset_n = 1'b0;
    drive_a(2'b00, 3'd0, 8'h11);
    drive_b(2'b11, 3'd1, 8'h01);
    #1;
    checks++; if (bus.Busy !== 1'b0 || bus.Rsp_Valid !== 1'b0 || bus.Rsp_Data !== 8'h00 || bus.Rsp_Id !== 1'b0) begin failures++; $display("FAIL rst2_outputs busy=%b valid=%b data=%h id=%b exp 0/0/00/0", bus.Busy, bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Id); end
    checks++; if ({bus.Sh_Direction, bus.Sh_Shift_Amount, bus.Sh_Data_In} !== 12'h000) begin failures++; $display("FAIL rst2_sh dir=%b amt=%0d din=%h exp all 0", bus.Sh_Direction, bus.Sh_Shift_Amount, bus.Sh_Data_In); end
    checks++; if (bus.Req_Ready_A !== 1'b0 || bus.Req_Ready_B !== 1'b0) begin failures++; $display("FAIL rst2_ready a=%b b=%b exp 0/0", bus.Req_Ready_A, bus.Req_Ready_B); end
    @(negedge Clock);
    @(negedge Clock);
    checks++; if (bus.Rsp_Valid !== 1'b0) begin failures++; $display("FAIL rst2_no_rsp got=%b exp=0", bus.Rsp_Valid); end
    Reset_n = 1'b1;
    #1;
    checks++; if (bus.Req_Ready_A !== 1'b1 || bus.Req_Ready_B !== 1'b0) begin failures++; $display("FAIL rst2_first_grant a=%b b=%b exp 1/0", bus.Req_Ready_A, bus.Req_Ready_B); end
    @(negedge Clock);
    clear_reqs();
    lat = 1;
    while (bus.Rsp_Valid !== 1'b1 && lat < 12) begin @(negedge Clock); lat++; end
    checks++; if (lat !== 3 || bus.Rsp_Id !== 1'b0 || bus.Rsp_Data !== 8'h11) begin failures++; $display("FAIL rst2_after lat=%0d id=%b data=%h exp 3/0/11", lat, bus.Rsp_Id, bus.Rsp_Data); end
    @(negedge Clock);
  endtask

  initial begin
    test_reset();
    test_shl();
    test_ror();
    test_rol();
    test_rot0();
    test_back_to_back();
    test_backpressure();
    test_reset_in_pass2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
